// File: rtl/glitch_sweep_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : glitch_sweep_sequencer
//  Description : Drives a target through repeated reset / delay / glitch /
//                wait attempts, sweeping glitch delay and width until the
//                target reports a success code or the sweep is exhausted.
//  Revision    : 1.0  initial release
// ============================================================================
module glitch_sweep_sequencer #(
    parameter logic [15:0] RESET_DURATION = 16'h0010,
    parameter logic [15:0] DELAY_MIN      = 16'h0001,
    parameter logic [15:0] DELAY_MAX      = 16'h0300,
    parameter logic [15:0] LEN_MIN        = 16'h0180,
    parameter logic [15:0] LEN_MAX        = 16'h0200,
    parameter logic [23:0] TIMEOUT        = 24'h100000,
    parameter logic [7:0]  SUCCESS_CODE   = 8'h88
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  debug_code,
    input  logic        debug_valid,
    output logic        reset_req,
    output logic        glitch_en,
    output logic        busy,
    output logic        hit,
    output logic        sweep_done,
    output logic        attempt_stb,
    output logic [15:0] cur_delay,
    output logic [15:0] cur_len
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RST  = 3'd1;
    localparam logic [2:0] ST_DLY  = 3'd2;
    localparam logic [2:0] ST_GLT  = 3'd3;
    localparam logic [2:0] ST_WAIT = 3'd4;
    localparam logic [2:0] ST_NEXT = 3'd5;
    localparam logic [2:0] ST_HIT  = 3'd6;

    // Counter loads are "cycles - 1"; a zero duration still costs one cycle.
    localparam logic [23:0] RST_LOAD  = (RESET_DURATION == 16'h0000) ? 24'h000000
                                        : {8'h00, RESET_DURATION - 16'h0001};
    localparam logic [23:0] WAIT_LOAD = (TIMEOUT == 24'h000000) ? 24'h000000
                                        : TIMEOUT - 24'h000001;

    logic [2:0]  state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [15:0] delay_q, delay_d;
    logic [15:0] len_q, len_d;
    logic        reset_req_q, glitch_en_q, attempt_stb_q, sweep_done_q;

    logic        w_success;
    logic        w_cnt_zero;
    logic [2:0]  w_post_dly_state, w_post_rst_state;
    logic [23:0] w_post_dly_cnt, w_post_rst_cnt;

    assign w_success  = debug_valid && (debug_code == SUCCESS_CODE);
    assign w_cnt_zero = (cnt_q == 24'h000000);

    // Where to go once a phase ends; zero-length phases are skipped entirely.
    assign w_post_dly_state = (len_q != 16'h0000) ? ST_GLT : ST_WAIT;
    assign w_post_dly_cnt   = (len_q != 16'h0000) ? {8'h00, len_q - 16'h0001} : WAIT_LOAD;
    assign w_post_rst_state = (delay_q != 16'h0000) ? ST_DLY : w_post_dly_state;
    assign w_post_rst_cnt   = (delay_q != 16'h0000) ? {8'h00, delay_q - 16'h0001} : w_post_dly_cnt;

    // Next-state, counter and sweep-parameter logic; abort overrides everything
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        delay_d = delay_q;
        len_d   = len_q;
        if (abort) begin
            state_d = ST_IDLE;
            cnt_d   = 24'h000000;
        end else begin
            case (state_q)
                ST_IDLE, ST_HIT: begin
                    if (start) begin
                        delay_d = DELAY_MIN;
                        len_d   = LEN_MIN;
                        state_d = ST_RST;
                        cnt_d   = RST_LOAD;
                    end
                end
                ST_RST: begin
                    if (w_cnt_zero) begin
                        state_d = w_post_rst_state;
                        cnt_d   = w_post_rst_cnt;
                    end else begin
                        cnt_d = cnt_q - 24'h000001;
                    end
                end
                ST_DLY: begin
                    if (w_cnt_zero) begin
                        state_d = w_post_dly_state;
                        cnt_d   = w_post_dly_cnt;
                    end else begin
                        cnt_d = cnt_q - 24'h000001;
                    end
                end
                ST_GLT: begin
                    if (w_cnt_zero) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        cnt_d = cnt_q - 24'h000001;
                    end
                end
                ST_WAIT: begin
                    // Success takes priority over a timeout in the same cycle
                    if (w_success) begin
                        state_d = ST_HIT;
                        cnt_d   = 24'h000000;
                    end else if (w_cnt_zero) begin
                        state_d = ST_NEXT;
                    end else begin
                        cnt_d = cnt_q - 24'h000001;
                    end
                end
                ST_NEXT: begin
                    if (delay_q < DELAY_MAX) begin
                        delay_d = delay_q + 16'h0001;
                        state_d = ST_RST;
                        cnt_d   = RST_LOAD;
                    end else if (len_q < LEN_MAX) begin
                        delay_d = DELAY_MIN;
                        len_d   = len_q + 16'h0001;
                        state_d = ST_RST;
                        cnt_d   = RST_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 24'h000000;
                end
            endcase
        end
    end

    // State registers; strobes and drive outputs are registered from the next state
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 24'h000000;
            delay_q       <= 16'h0000;
            len_q         <= 16'h0000;
            reset_req_q   <= 1'b0;
            glitch_en_q   <= 1'b0;
            attempt_stb_q <= 1'b0;
            sweep_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            delay_q       <= delay_d;
            len_q         <= len_d;
            reset_req_q   <= (state_d == ST_RST);
            glitch_en_q   <= (state_d == ST_GLT);
            attempt_stb_q <= (state_d == ST_NEXT);
            sweep_done_q  <= (state_d == ST_NEXT) && (delay_q >= DELAY_MAX) && (len_q >= LEN_MAX);
        end
    end

    assign reset_req   = reset_req_q;
    assign glitch_en   = glitch_en_q;
    assign attempt_stb = attempt_stb_q;
    assign sweep_done  = sweep_done_q;
    assign busy        = (state_q != ST_IDLE) && (state_q != ST_HIT);
    assign hit         = (state_q == ST_HIT);
    assign cur_delay   = delay_q;
    assign cur_len     = len_q;

endmodule
`default_nettype wire

// File: tb/tb_glitch_sweep_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_glitch_sweep_sequencer
//  Description : Self-checking bench for glitch_sweep_sequencer. Three
//                instances with different parameter sets share clock/reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_glitch_sweep_sequencer;

    localparam int N      = 3;
    localparam int M_IDLE = 0;
    localparam int M_ATT  = 1;
    localparam int M_HIT  = 2;

    typedef struct { int rd; int dmin; int dmax; int lmin; int lmax; int tmo; } cfg_t;
    typedef struct { int mode; int t; int d; int l; } mdl_t;
    typedef struct { logic rr; logic ge; logic busy; logic hit; logic stb; logic done;
                     logic [15:0] cd; logic [15:0] cl; } exp_t;
    typedef struct { logic st; logic ab; logic dv; logic [7:0] dc; exp_t e; } vec_t;

    logic CLK = 1'b0;
    logic RST_N;
    logic [N-1:0]       start_v, abort_v, dv_v;
    logic [N-1:0][7:0]  dc_v;
    logic [N-1:0]       rr, ge, busy, hit, done, stb;
    logic [N-1:0][15:0] cd, cl;

    int errors = 0;
    int checks = 0;
    mdl_t m[N];
    vec_t tbl[19];

    always #5 CLK = ~CLK;

    glitch_sweep_sequencer #(.RESET_DURATION(16'd4), .DELAY_MIN(16'd2), .DELAY_MAX(16'd3),
        .LEN_MIN(16'd3), .LEN_MAX(16'd4), .TIMEOUT(24'd10), .SUCCESS_CODE(8'h88)) u_a (
        .CLK(CLK), .RST_N(RST_N), .start(start_v[0]), .abort(abort_v[0]),
        .debug_code(dc_v[0]), .debug_valid(dv_v[0]), .reset_req(rr[0]), .glitch_en(ge[0]),
        .busy(busy[0]), .hit(hit[0]), .sweep_done(done[0]), .attempt_stb(stb[0]),
        .cur_delay(cd[0]), .cur_len(cl[0]));

    glitch_sweep_sequencer #(.RESET_DURATION(16'd4), .DELAY_MIN(16'd1), .DELAY_MAX(16'd2),
        .LEN_MIN(16'd5), .LEN_MAX(16'd6), .TIMEOUT(24'd6), .SUCCESS_CODE(8'h88)) u_b (
        .CLK(CLK), .RST_N(RST_N), .start(start_v[1]), .abort(abort_v[1]),
        .debug_code(dc_v[1]), .debug_valid(dv_v[1]), .reset_req(rr[1]), .glitch_en(ge[1]),
        .busy(busy[1]), .hit(hit[1]), .sweep_done(done[1]), .attempt_stb(stb[1]),
        .cur_delay(cd[1]), .cur_len(cl[1]));

    glitch_sweep_sequencer #(.RESET_DURATION(16'd0), .DELAY_MIN(16'd0), .DELAY_MAX(16'd1),
        .LEN_MIN(16'd0), .LEN_MAX(16'd1), .TIMEOUT(24'd3), .SUCCESS_CODE(8'h88)) u_c (
        .CLK(CLK), .RST_N(RST_N), .start(start_v[2]), .abort(abort_v[2]),
        .debug_code(dc_v[2]), .debug_valid(dv_v[2]), .reset_req(rr[2]), .glitch_en(ge[2]),
        .busy(busy[2]), .hit(hit[2]), .sweep_done(done[2]), .attempt_stb(stb[2]),
        .cur_delay(cd[2]), .cur_len(cl[2]));

    function automatic cfg_t get_cfg(int k);
        cfg_t c;
        case (k)
            0:       c = '{4, 2, 3, 3, 4, 10};
            1:       c = '{4, 1, 2, 5, 6, 6};
            default: c = '{0, 0, 1, 0, 1, 3};
        endcase
        return c;
    endfunction

    // Reference model: an attempt is a timeline of length r+d+l+T+1 indexed by t;
    // every output is a window test on t.
    function automatic mdl_t step(cfg_t c, mdl_t s, logic st, logic ab, logic dv, logic [7:0] dc);
        mdl_t n = s;
        int r = (c.rd == 0) ? 1 : c.rd;
        int w0 = r + s.d + s.l;
        if (ab) n.mode = M_IDLE;
        else if (s.mode != M_ATT) begin
            if (st) begin n.mode = M_ATT; n.t = 0; n.d = c.dmin; n.l = c.lmin; end
        end else if (s.t >= w0 && s.t < w0 + c.tmo && dv && dc == 8'h88) n.mode = M_HIT;
        else if (s.t == w0 + c.tmo) begin
            if (s.d < c.dmax) begin n.d = s.d + 1; n.t = 0; end
            else if (s.l < c.lmax) begin n.d = c.dmin; n.l = s.l + 1; n.t = 0; end
            else n.mode = M_IDLE;
        end else n.t = s.t + 1;
        return n;
    endfunction

    function automatic exp_t expect_of(cfg_t c, mdl_t s);
        exp_t e;
        int r = (c.rd == 0) ? 1 : c.rd;
        int w0 = r + s.d + s.l;
        logic a = (s.mode == M_ATT);
        e.rr   = a && s.t < r;
        e.ge   = a && s.t >= r + s.d && s.t < w0;
        e.busy = a;
        e.hit  = (s.mode == M_HIT);
        e.stb  = a && s.t == w0 + c.tmo;
        e.done = e.stb && s.d >= c.dmax && s.l >= c.lmax;
        e.cd   = 16'(s.d);
        e.cl   = 16'(s.l);
        return e;
    endfunction

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int k = 0; k < N; k++) m[k] <= '{M_IDLE, 0, 0, 0};
        end else begin
            for (int k = 0; k < N; k++)
                m[k] <= step(get_cfg(k), m[k], start_v[k], abort_v[k], dv_v[k], dc_v[k]);
        end
    end

    task automatic chk(string name, int k, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    task automatic chk_out(string tag, int k, exp_t e);
        chk({tag, ".reset_req"},   k, 16'(rr[k]),   16'(e.rr));
        chk({tag, ".glitch_en"},   k, 16'(ge[k]),   16'(e.ge));
        chk({tag, ".busy"},        k, 16'(busy[k]), 16'(e.busy));
        chk({tag, ".hit"},         k, 16'(hit[k]),  16'(e.hit));
        chk({tag, ".attempt_stb"}, k, 16'(stb[k]),  16'(e.stb));
        chk({tag, ".sweep_done"},  k, 16'(done[k]), 16'(e.done));
        chk({tag, ".cur_delay"},   k, cd[k],        e.cd);
        chk({tag, ".cur_len"},     k, cl[k],        e.cl);
    endtask

    task automatic tick_chk(string tag);
        @(posedge CLK);
        #1;
        for (int k = 0; k < N; k++) chk_out({tag, ".model"}, k, expect_of(get_cfg(k), m[k]));
    endtask

    task automatic drive(int k, logic st, logic ab, logic dv, logic [7:0] dc);
        start_v[k] = st; abort_v[k] = ab; dv_v[k] = dv; dc_v[k] = dc;
    endtask

    task automatic clear_all();
        for (int k = 0; k < N; k++) drive(k, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    function automatic vec_t v(logic st, logic ab, logic dv, logic [7:0] dc,
                               logic r_, logic g_, logic b_, logic h_, int d_, int l_);
        vec_t x;
        x.st = st; x.ab = ab; x.dv = dv; x.dc = dc;
        x.e = '{r_, g_, b_, h_, 1'b0, 1'b0, 16'(d_), 16'(l_)};
        return x;
    endfunction

    exp_t zero_e;
    int   n_stb;
    logic [15:0] rec_d[4], rec_l[4];
    logic rec_done[4];
    logic ok;

    initial begin
        // Instance u_a: RESET_DURATION=4, DELAY_MIN=2, LEN_MIN=3, TIMEOUT=10
        tbl[0]  = v(1, 0, 0, 8'h00, 1, 0, 1, 0, 2, 3);
        tbl[1]  = v(0, 0, 0, 8'h00, 1, 0, 1, 0, 2, 3);
        tbl[2]  = v(1, 0, 0, 8'h00, 1, 0, 1, 0, 2, 3);   // start while busy is ignored
        tbl[3]  = v(0, 0, 0, 8'h00, 1, 0, 1, 0, 2, 3);
        tbl[4]  = v(0, 0, 0, 8'h00, 0, 0, 1, 0, 2, 3);
        tbl[5]  = v(0, 0, 1, 8'h88, 0, 0, 1, 0, 2, 3);   // success code outside WAIT ignored
        tbl[6]  = v(0, 0, 0, 8'h00, 0, 1, 1, 0, 2, 3);
        tbl[7]  = v(0, 0, 0, 8'h00, 0, 1, 1, 0, 2, 3);
        tbl[8]  = v(0, 0, 0, 8'h00, 0, 1, 1, 0, 2, 3);
        tbl[9]  = v(0, 0, 0, 8'h00, 0, 0, 1, 0, 2, 3);
        tbl[10] = v(0, 0, 0, 8'h00, 0, 0, 1, 0, 2, 3);
        tbl[11] = v(0, 0, 0, 8'h00, 0, 0, 1, 0, 2, 3);
        tbl[12] = v(0, 0, 0, 8'h00, 0, 0, 1, 0, 2, 3);
        tbl[13] = v(0, 0, 1, 8'h87, 0, 0, 1, 0, 2, 3);   // wrong code ignored
        tbl[14] = v(0, 0, 1, 8'h88, 0, 0, 0, 1, 2, 3);   // success in WAIT cycle 5
        tbl[15] = v(0, 0, 0, 8'h00, 0, 0, 0, 1, 2, 3);
        tbl[16] = v(0, 1, 0, 8'h00, 0, 0, 0, 0, 2, 3);   // abort out of HIT
        tbl[17] = v(1, 1, 0, 8'h00, 0, 0, 0, 0, 2, 3);   // start+abort: abort wins
        tbl[18] = v(0, 0, 0, 8'h00, 0, 0, 0, 0, 2, 3);
        zero_e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0};

        // Reset values while RST_N is low
        clear_all();
        RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        for (int k = 0; k < N; k++) chk_out("reset", k, zero_e);
        RST_N = 1'b1;
        // No sweep starts without a start pulse
        for (int i = 0; i < 4; i++) tick_chk("post_reset");
        for (int k = 0; k < N; k++) chk_out("idle_after_reset", k, zero_e);

        // Table-driven basic timing / success / simultaneous events on u_a
        for (int i = 0; i < 19; i++) begin
            drive(0, tbl[i].st, tbl[i].ab, tbl[i].dv, tbl[i].dc);
            tick_chk("vec");
            chk_out($sformatf("vec%0d", i), 0, tbl[i].e);
        end
        clear_all();

        // Sweep wrap on u_b: (1,5) (2,5) (1,6) (2,6), sweep_done with the last strobe
        drive(1, 1'b1, 1'b0, 1'b0, 8'h00);
        tick_chk("wrap_start");
        clear_all();
        n_stb = 0;
        ok = 1'b0;
        for (int c = 0; c < 400 && !ok; c++) begin
            tick_chk("wrap");
            if (stb[1]) begin
                if (n_stb < 4) begin
                    rec_d[n_stb] = cd[1]; rec_l[n_stb] = cl[1]; rec_done[n_stb] = done[1];
                end
                n_stb++;
            end
            if (done[1] && !stb[1]) chk("wrap_done_without_stb", 1, 16'(done[1]), 16'd0);
            if (n_stb >= 4 && !busy[1]) ok = 1'b1;
        end
        chk("wrap_finished", 1, 16'(ok), 16'd1);
        chk("wrap_stb_count", 1, 16'(n_stb), 16'd4);
        if (n_stb == 4) begin
            chk("wrap_d0", 1, rec_d[0], 16'd1); chk("wrap_l0", 1, rec_l[0], 16'd5);
            chk("wrap_d1", 1, rec_d[1], 16'd2); chk("wrap_l1", 1, rec_l[1], 16'd5);
            chk("wrap_d2", 1, rec_d[2], 16'd1); chk("wrap_l2", 1, rec_l[2], 16'd6);
            chk("wrap_d3", 1, rec_d[3], 16'd2); chk("wrap_l3", 1, rec_l[3], 16'd6);
            chk("wrap_done0", 1, 16'(rec_done[0]), 16'd0);
            chk("wrap_done2", 1, 16'(rec_done[2]), 16'd0);
            chk("wrap_done3", 1, 16'(rec_done[3]), 16'd1);
        end
        chk("wrap_hold_d", 1, cd[1], 16'd2);
        chk("wrap_hold_l", 1, cl[1], 16'd6);

        // Abort during GLT of the second attempt (delay 3) on u_a
        drive(0, 1'b1, 1'b0, 1'b0, 8'h00);
        tick_chk("abort_start");
        clear_all();
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            tick_chk("abort_wait");
            if (ge[0] && cd[0] == 16'd3) ok = 1'b1;
        end
        chk("abort_reached_glt", 0, 16'(ok), 16'd1);
        drive(0, 1'b0, 1'b1, 1'b0, 8'h00);
        tick_chk("abort");
        clear_all();
        chk_out("abort_glt", 0, '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3, 16'd3});
        drive(0, 1'b1, 1'b0, 1'b0, 8'h00);
        tick_chk("restart");
        clear_all();
        chk_out("restart", 0, '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2, 16'd3});

        // Success in the last WAIT cycle resolves to HIT, not NEXT
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            tick_chk("last_wait_ge");
            if (ge[0]) ok = 1'b1;
        end
        for (int c = 0; c < 100 && ok; c++) begin
            tick_chk("last_wait_fall");
            if (!ge[0]) ok = 1'b0;
        end
        chk("last_wait_entered", 0, 16'(ok), 16'd0);
        for (int j = 1; j <= 9; j++) tick_chk("last_wait");
        chk("last_wait_busy", 0, 16'(busy[0]), 16'd1);
        drive(0, 1'b0, 1'b0, 1'b1, 8'h88);
        tick_chk("last_wait_hit");
        clear_all();
        chk_out("last_wait_hit", 0, '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd2, 16'd3});

        // Asynchronous reset during GLT
        drive(0, 1'b1, 1'b0, 1'b0, 8'h00);
        tick_chk("areset_start");
        clear_all();
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            tick_chk("areset_wait");
            if (ge[0]) ok = 1'b1;
        end
        chk("areset_reached_glt", 0, 16'(ok), 16'd1);
        #3 RST_N = 1'b0;
        #1;
        for (int k = 0; k < N; k++) chk_out("areset", k, zero_e);
        @(posedge CLK);
        #1 RST_N = 1'b1;
        for (int i = 0; i < 3; i++) tick_chk("areset_release");
        chk("areset_no_autostart", 0, 16'(busy[0]), 16'd0);

        // Randomized stimulus against the reference model, all instances
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < N; k++)
                drive(k, $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0,
                      $urandom_range(0, 7) == 0,
                      ($urandom_range(0, 1) == 0) ? 8'h88 : 8'($urandom));
            tick_chk("rand");
        end
        clear_all();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
